fetch_unit: RTL

- Owns the program counter for the RV32I core and fetches one instruction per step from instruction memory over a req/ack handshake.
- Presents each instruction and its PC to decode with a valid/ready handshake.
- Accepts the next-PC value that the core's branch/next-PC logic computes, and loads it as the new PC.
- Detects misaligned next-PC targets and instruction-memory timeouts, then halts with a sticky fault.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the RV32I instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_TIMEOUT  = 2'b10
    } fault_code_t;

endpackage

// File: rtl/fetch_unit.sv
// Program counter owner: fetches one instruction per step over req/ack and
// hands it to decode over valid/ready, halting on misaligned targets or timeouts.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic            clock,
    input  logic            nReset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            insn_valid,
    input  logic            insn_ready,
    output logic [XLEN-1:0] insn_out,
    output logic [XLEN-1:0] pc_out,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] instret,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TMO_EN = (TIMEOUT != 0);

    fetch_state_t    state_q, state_d;
    fault_code_t     code_q, code_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] insn_q, insn_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;

    // Next-state and next-register values; status flags follow the next state.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        pc_d      = pc_q;
        insn_d    = insn_q;
        instret_d = instret_q;
        tmo_d     = tmo_q;

        unique case (state_q)
            REQ: begin
                // req_q is low only in the first cycle after reset; nothing is outstanding then.
                if (req_q && imem_ack) begin
                    insn_d  = imem_rdata;
                    state_d = ISSUE;
                end else if (req_q && TMO_EN) begin
                    if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = FAULT;
                        code_d  = FC_TIMEOUT;
                    end else begin
                        tmo_d = tmo_q + CNT_W'(1);
                    end
                end
            end
            ISSUE: begin
                if (insn_ready) begin
                    instret_d = instret_q + XLEN'(1);
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        tmo_d   = '0;
                        state_d = REQ;
                    end else begin
                        state_d = FAULT;
                        code_d  = FC_MISALIGN;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        req_d   = (state_d == REQ);
        valid_d = (state_d == ISSUE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= REQ;
            code_q    <= FC_NONE;
            pc_q      <= RESET_PC;
            insn_q    <= '0;
            instret_q <= '0;
            tmo_q     <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
            insn_q    <= insn_d;
            instret_q <= instret_d;
            tmo_q     <= tmo_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc_out     = pc_q;
    assign insn_valid = valid_q;
    assign insn_out   = insn_q;
    assign instret    = instret_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule
